uart_loopback_checker: RTL and testbench

- Host-side initiator for the UART echo path. It drives a pseudo-random byte stream into a uart_tx-style ready/valid port and checks the bytes returned by a uart_rx-style valid-only port.
- Counts mismatches, parity/frame errors, unexpected bytes and timeouts.
- Sits in the board top between the UART PHY modules and LEDs/switches, or in simulation as the far end of the echo design.

---
 rtl/uart_loopback_checker.sv | 200 ++++++++++++++++++++
 tb/tb_uart_loopback_checker.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_checker.sv
// UART loopback checker: sends an LFSR-generated byte stream over a ready/valid
// transmit port and checks the echoed bytes that come back on a valid-only
// receive port. Counts mismatches, parity/frame errors, unexpected bytes and
// idle timeouts. Reports the result as pass/fail once the run completes.
module uart_loopback_checker #(
  parameter int unsigned data_bits_p       = 8,
  parameter logic [15:0] seed_p            = 16'hACE1,
  parameter int unsigned count_width_p     = 16,
  parameter int unsigned max_outstanding_p = 8,
  parameter int unsigned timeout_cycles_p  = 100000,
  parameter int unsigned err_width_p       = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic [count_width_p-1:0] count_i,
  output logic                     tx_v_o,
  output logic [data_bits_p-1:0]   tx_o,
  input  logic                     tx_ready_and_i,
  input  logic                     rx_v_i,
  input  logic [data_bits_p-1:0]   rx_i,
  input  logic                     rx_parity_error_i,
  input  logic                     rx_frame_error_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [err_width_p-1:0]   error_count_o
);

  localparam int unsigned timer_width_lp = $clog2(timeout_cycles_p + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Fibonacci LFSR x^16+x^15+x^13+x^4+1, shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  state_e                    state_q;
  logic [15:0]               gen_q, gen_d;
  logic [15:0]               exp_q, exp_d;
  logic [count_width_p-1:0]  count_q;
  logic [count_width_p-1:0]  sent_q, sent_d;
  logic [count_width_p-1:0]  recv_q, recv_d;
  logic [count_width_p-1:0]  outs_q, outs_d;
  logic [timer_width_lp-1:0] timer_q, timer_d;
  logic [err_width_p-1:0]    err_q, err_d;
  logic                      timeout_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      pass_q;

  logic                      in_run;
  logic                      hs;
  logic                      rx_take;
  logic                      in_seq;
  logic                      unexpected;
  logic                      mismatch;
  logic                      timer_clr;
  logic                      timer_hit;
  logic [1:0]                err_inc;
  logic [err_width_p+1:0]    err_sum;

  assign in_run = (state_q == StRun);

  // Valid depends only on registered state so the transmitter never sees a
  // combinational path from its own ready back to valid.
  assign tx_v_o = in_run && (sent_q < count_q)
                  && (outs_q < count_width_p'(max_outstanding_p));
  assign tx_o   = gen_q[data_bits_p-1:0];

  assign hs         = tx_v_o & tx_ready_and_i;
  assign rx_take    = in_run & rx_v_i;
  // A byte arriving in the same cycle as a send still counts as in-sequence.
  assign in_seq     = rx_take & ((outs_q != '0) | hs);
  assign unexpected = rx_take & ~in_seq;
  assign mismatch   = in_seq & (rx_i != exp_q[data_bits_p-1:0]);

  assign timer_clr  = rx_v_i | hs | (outs_q == '0);
  assign timer_hit  = in_run & ~timer_clr
                      & (timer_q == timer_width_lp'(timeout_cycles_p - 1));

  // Datapath next-state values used while running.
  always_comb begin
    gen_d  = hs ? lfsr_next(gen_q) : gen_q;
    exp_d  = in_seq ? lfsr_next(exp_q) : exp_q;
    sent_d = sent_q + count_width_p'(hs);
    recv_d = recv_q + count_width_p'(in_seq);

    outs_d = outs_q;
    if (hs && !in_seq) begin
      outs_d = outs_q + count_width_p'(1);
    end else if (!hs && in_seq) begin
      outs_d = outs_q - count_width_p'(1);
    end

    timer_d = timer_q;
    if (timer_clr) begin
      timer_d = '0;
    end else if (in_run) begin
      timer_d = timer_q + timer_width_lp'(1);
    end

    // mismatch and unexpected are exclusive, so at most three errors per cycle.
    err_inc = 2'(mismatch) + 2'(unexpected)
              + 2'(rx_take & rx_parity_error_i)
              + 2'(rx_take & rx_frame_error_i);
    err_sum = {2'b00, err_q} + (err_width_p + 2)'(err_inc);
    if (err_sum[err_width_p+1:err_width_p] != 2'b00) begin
      err_d = '1;
    end else begin
      err_d = err_sum[err_width_p-1:0];
    end
  end

  // Control FSM with registered status outputs and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      gen_q     <= seed_p;
      exp_q     <= seed_p;
      count_q   <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      outs_q    <= '0;
      timer_q   <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            gen_q     <= seed_p;
            exp_q     <= seed_p;
            count_q   <= count_i;
            sent_q    <= '0;
            recv_q    <= '0;
            outs_q    <= '0;
            timer_q   <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            if (count_i == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end
        StRun: begin
          gen_q   <= gen_d;
          exp_q   <= exp_d;
          sent_q  <= sent_d;
          recv_q  <= recv_d;
          outs_q  <= outs_d;
          timer_q <= timer_d;
          err_q   <= err_d;
          if (recv_d == count_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else if (timer_hit) begin
            state_q   <= StDone;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign error_count_o = err_q;

endmodule

// File: tb/tb_uart_loopback_checker.sv
// Directed bench for uart_loopback_checker: drives an echo far end, checks the
// LFSR byte sequence, error counting, saturation, timeout and reset behaviour.
module tb_uart_loopback_checker;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [15:0] count_i;
  logic        tx_v_o;
  logic [7:0]  tx_o;
  logic        tx_ready_and_i;
  logic        rx_v_i;
  logic [7:0]  rx_i;
  logic        rx_parity_error_i;
  logic        rx_frame_error_i;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic        timeout_o;
  logic [7:0]  error_count_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] b;
    int         due;
    int         idx;
  } echo_t;

  echo_t      pend[$];
  logic [7:0] txlog[$];
  logic [7:0] exp_seq[4] = '{8'hE1, 8'hC3, 8'h86, 8'h0C};

  uart_loopback_checker #(
    .data_bits_p      (8),
    .seed_p           (16'hACE1),
    .count_width_p    (16),
    .max_outstanding_p(8),
    .timeout_cycles_p (TO),
    .err_width_p      (8)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n_i),
    .start_i          (start_i),
    .count_i          (count_i),
    .tx_v_o           (tx_v_o),
    .tx_o             (tx_o),
    .tx_ready_and_i   (tx_ready_and_i),
    .rx_v_i           (rx_v_i),
    .rx_i             (rx_i),
    .rx_parity_error_i(rx_parity_error_i),
    .rx_frame_error_i (rx_frame_error_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .timeout_o        (timeout_o),
    .error_count_o    (error_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    start_i = 1'b0;
    count_i = '0;
    tx_ready_and_i = 1'b0;
    rx_v_i = 1'b0;
    rx_i = '0;
    rx_parity_error_i = 1'b0;
    rx_frame_error_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
  endtask

  // Run one transfer with an echo far end returning each byte 10 cycles later.
  task automatic run_echo(input int n, input int corrupt, input bit rnd);
    echo_t      e;
    bit         held;
    logic [7:0] held_b;
    bit         hs;
    logic [7:0] b;
    bit         last_rx;
    txlog.delete();
    pend.delete();
    held = 1'b0;
    held_b = '0;
    count_i = 16'(n);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 2000 && !done_o; k++) begin
      tx_ready_and_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      last_rx = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        e = pend.pop_front();
        rx_v_i = 1'b1;
        rx_i = e.b ^ ((e.idx == corrupt) ? 8'h01 : 8'h00);
        last_rx = (e.idx == n);
      end else begin
        rx_v_i = 1'b0;
        rx_i = '0;
      end
      if (held) begin
        n_vec++;
        if (tx_v_o !== 1'b1 || tx_o !== held_b) begin
          n_err++;
          $display("FAIL tx_hold: tx_v_o=%b tx_o=%h required tx_v_o=1 tx_o=%h", tx_v_o, tx_o, held_b);
        end
      end
      hs = tx_v_o && tx_ready_and_i;
      b = tx_o;
      held = tx_v_o && !hs;
      held_b = tx_o;
      tick();
      if (hs) begin
        txlog.push_back(b);
        e.b = b;
        e.due = cyc + 10;
        e.idx = txlog.size();
        pend.push_back(e);
      end
      if (last_rx) begin
        n_vec++;
        if (done_o !== 1'b1) begin
          n_err++;
          $display("FAIL done_latency: done_o=%b required 1", done_o);
        end
      end
    end
    rx_v_i = 1'b0;
    rx_i = '0;
    tx_ready_and_i = 1'b0;
    n_vec++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL run_budget: done_o=%b required 1 within 2000 cycles", done_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({tx_v_o, busy_o, done_o, pass_o, timeout_o} !== 5'b0 || error_count_o !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: tx_v/busy/done/pass/timeout=%b err=%h required 00000 00",
               {tx_v_o, busy_o, done_o, pass_o, timeout_o}, error_count_o);
    end
    rx_v_i = 1'b1;
    rx_i = 8'h55;
    rx_parity_error_i = 1'b1;
    rx_frame_error_i = 1'b1;
    tick();
    rx_v_i = 1'b0;
    rx_parity_error_i = 1'b0;
    rx_frame_error_i = 1'b0;
    tick();
    n_vec++;
    if (error_count_o !== 8'h00 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_rx_ignored: err=%h busy=%b required 00 0", error_count_o, busy_o);
    end
  endtask

  task automatic check_sequence(input string name);
    n_vec++;
    if (txlog.size() != 4) begin
      n_err++;
      $display("FAIL %s_len: bytes sent=%0d required 4", name, txlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (txlog[i] !== exp_seq[i]) begin
          n_err++;
          $display("FAIL %s_byte%0d: tx=%h required %h", name, i, txlog[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_ideal_echo();
    do_reset();
    run_echo(4, 0, 1'b0);
    check_sequence("ideal");
    n_vec++;
    if (done_o !== 1'b1 || pass_o !== 1'b1 || error_count_o !== 8'h00 || timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL ideal_status: done=%b pass=%b err=%h timeout=%b busy=%b required 1 1 00 0 0",
               done_o, pass_o, error_count_o, timeout_o, busy_o);
    end
    // Stray bytes in DONE must not disturb the held result.
    for (int i = 0; i < 3; i++) begin
      rx_v_i = 1'b1;
      rx_i = 8'hFF;
      rx_parity_error_i = 1'b1;
      rx_frame_error_i = 1'b1;
      tick();
    end
    rx_v_i = 1'b0;
    rx_parity_error_i = 1'b0;
    rx_frame_error_i = 1'b0;
    tick();
    n_vec++;
    if (done_o !== 1'b1 || pass_o !== 1'b1 || error_count_o !== 8'h00 || tx_v_o !== 1'b0) begin
      n_err++;
      $display("FAIL done_hold: done=%b pass=%b err=%h tx_v=%b required 1 1 00 0",
               done_o, pass_o, error_count_o, tx_v_o);
    end
  endtask

  task automatic test_corrupt();
    run_echo(4, 2, 1'b0);
    check_sequence("corrupt");
    n_vec++;
    if (done_o !== 1'b1 || pass_o !== 1'b0 || error_count_o !== 8'h01 || timeout_o !== 1'b0) begin
      n_err++;
      $display("FAIL corrupt_status: done=%b pass=%b err=%h timeout=%b required 1 0 01 0",
               done_o, pass_o, error_count_o, timeout_o);
    end
  endtask

  task automatic test_back_to_back();
    run_echo(4, 0, 1'b1);
    check_sequence("random_ready");
    n_vec++;
    if (done_o !== 1'b1 || pass_o !== 1'b1 || error_count_o !== 8'h00) begin
      n_err++;
      $display("FAIL random_ready_status: done=%b pass=%b err=%h required 1 1 00",
               done_o, pass_o, error_count_o);
    end
  endtask

  task automatic test_timeout();
    int  hs_cnt;
    int  last;
    bit  hs;
    do_reset();
    count_i = 16'd20;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tx_ready_and_i = 1'b1;
    hs_cnt = 0;
    last = cyc;
    for (int k = 0; k < 500 && !done_o; k++) begin
      hs = tx_v_o && tx_ready_and_i;
      tick();
      if (hs) begin
        hs_cnt++;
        last = cyc;
      end
    end
    tx_ready_and_i = 1'b0;
    n_vec++;
    if (hs_cnt != 8) begin
      n_err++;
      $display("FAIL timeout_handshakes: handshakes=%0d required 8", hs_cnt);
    end
    n_vec++;
    if (cyc - last != TO) begin
      n_err++;
      $display("FAIL timeout_delay: idle cycles=%0d required %0d", cyc - last, TO);
    end
    n_vec++;
    if (timeout_o !== 1'b1 || done_o !== 1'b1 || pass_o !== 1'b0 || tx_v_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_status: timeout=%b done=%b pass=%b tx_v=%b busy=%b required 1 1 0 0 0",
               timeout_o, done_o, pass_o, tx_v_o, busy_o);
    end
  endtask

  task automatic test_error_saturation();
    do_reset();
    count_i = 16'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tx_ready_and_i = 1'b1;
    tick();
    tx_ready_and_i = 1'b0;
    // One outstanding byte (E1): a wrong byte with both flags costs 3.
    rx_v_i = 1'b1;
    rx_i = 8'h00;
    rx_parity_error_i = 1'b1;
    rx_frame_error_i = 1'b1;
    tick();
    rx_v_i = 1'b0;
    tick();
    n_vec++;
    if (error_count_o !== 8'd3 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL triple_error: err=%0d busy=%b required 3 1", error_count_o, busy_o);
    end
    // Unexpected bytes with both flags: 3 each, 84 of them lands exactly on 255.
    for (int i = 0; i < 84; i++) begin
      rx_v_i = 1'b1;
      tick();
    end
    rx_v_i = 1'b0;
    tick();
    n_vec++;
    if (error_count_o !== 8'd255) begin
      n_err++;
      $display("FAIL sat_reach: err=%0d required 255", error_count_o);
    end
    rx_parity_error_i = 1'b0;
    rx_frame_error_i = 1'b0;
    rx_v_i = 1'b1;
    tick();
    rx_parity_error_i = 1'b1;
    rx_frame_error_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    rx_v_i = 1'b0;
    rx_parity_error_i = 1'b0;
    rx_frame_error_i = 1'b0;
    tick();
    n_vec++;
    if (error_count_o !== 8'd255 || done_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_err++;
      $display("FAIL sat_hold: err=%0d done=%b timeout=%b required 255 0 0",
               error_count_o, done_o, timeout_o);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    count_i = 16'd10;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tx_ready_and_i = 1'b1;
    tick();
    tick();
    tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    tx_ready_and_i = 1'b0;
    n_vec++;
    if ({tx_v_o, busy_o, done_o, pass_o, timeout_o} !== 5'b0 || error_count_o !== 8'h00) begin
      n_err++;
      $display("FAIL midrun_reset: tx_v/busy/done/pass/timeout=%b err=%h required 00000 00",
               {tx_v_o, busy_o, done_o, pass_o, timeout_o}, error_count_o);
    end
    count_i = 16'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_vec++;
    if (tx_v_o !== 1'b1 || tx_o !== 8'hE1 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL first_tx: tx_v=%b tx=%h busy=%b required 1 e1 1", tx_v_o, tx_o, busy_o);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    count_i = 16'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_vec++;
    if (done_o !== 1'b1 || pass_o !== 1'b1 || tx_v_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_count: done=%b pass=%b tx_v=%b busy=%b required 1 1 0 0",
               done_o, pass_o, tx_v_o, busy_o);
    end
    tick();
    n_vec++;
    if (done_o !== 1'b1 || tx_v_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_count_hold: done=%b tx_v=%b required 1 0", done_o, tx_v_o);
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    start_i = 1'b0;
    count_i = '0;
    tx_ready_and_i = 1'b0;
    rx_v_i = 1'b0;
    rx_i = '0;
    rx_parity_error_i = 1'b0;
    rx_frame_error_i = 1'b0;
    test_reset();
    test_ideal_echo();
    test_corrupt();
    test_back_to_back();
    test_timeout();
    test_error_saturation();
    test_reset_mid_run();
    test_zero_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
